// File: rtl/demux_dispatch_pkg.sv
// Shared constants and mode encoding for the 1-to-4 stream dispatcher.
package demux_dispatch_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned SNUM_DEF  = 2;
  localparam int unsigned NCH       = 4;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

endpackage

// File: rtl/demux_dispatch_1to4_slot.sv
// Single-entry valid/ready output slot; data reads zero whenever the slot is empty.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain in the same cycle, which keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_dispatch_1to4.sv
// Registered 1-to-4 dispatcher: explicit or round-robin routing into four output slots.
module demux_dispatch_1to4
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SNUM  = SNUM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SNUM-1:0]  in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [SNUM-1:0]  rr_ptr,
  output logic             busy
);

  logic [SNUM-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SNUM-1:0]  tgt;
  logic             acc;
  logic [3:0]       load;
  logic [WIDTH-1:0] slot_data [NCH];

  assign tgt = (mode == MODE_RR) ? rr_ptr_q : in_dest;

  // Intentional combinational path from out_ready to in_ready for full throughput.
  assign in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
  assign acc      = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    if (acc) begin
      unique case (tgt)
        2'd0:    load = 4'b0001;
        2'd1:    load = 4'b0010;
        2'd2:    load = 4'b0100;
        2'd3:    load = 4'b1000;
        default: load = 4'b0000;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (acc && (mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + SNUM'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (slot_data[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign rr_ptr    = rr_ptr_q;
  assign busy      = |out_valid;

endmodule

// File: tb/tb_demux_dispatch_1to4.sv
// Directed and randomized self-checking bench for demux_dispatch_1to4.
module tb_demux_dispatch_1to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: slot contents as plain arrays and an integer pointer.
  bit       m_valid [4];
  int       m_data  [4];
  int       m_ptr;

  always #5 clk = ~clk;

  demux_dispatch_1to4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_target();
    return mode ? m_ptr : int'(in_dest);
  endfunction

  function automatic bit m_in_ready();
    int t = m_target();
    return rst_n && (!m_valid[t] || out_ready[t]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 0;
      m_data[k]  = 0;
    end
    m_ptr = 0;
  endtask

  task automatic compare_all();
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_valid[k];
      ed[8*k +: 8]   = 8'(m_data[k]);
    end
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", {out_data3, out_data2, out_data1, out_data0}, ed);
    chk("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    chk("busy", 32'(busy), 32'(|ev));
  endtask

  task automatic m_update();
    int t;
    bit a;
    if (!rst_n) begin
      m_reset();
      return;
    end
    t = m_target();
    a = in_valid && m_in_ready();
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k] && out_ready[k]) begin
        m_valid[k] = 0;
        m_data[k]  = 0;
      end
    end
    if (a) begin
      m_valid[t] = 1;
      m_data[t]  = int'(in_data);
      if (mode) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  // Check at the falling edge, advance the model, then move past the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_w [4];
  logic [1:0] exp_d [4];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    in_dest   = 2'd0;
    mode      = 1'b1;
    out_ready = 4'h0;
    @(posedge clk);
    #1;
    m_reset();

    // Reset held two cycles with a word offered.
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_data0", 32'(out_data0), 32'hAA);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    step();

    // Explicit routing.
    exp_w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_d = '{2'd3, 2'd2, 2'd1, 2'd0};
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = exp_w[i];
      in_dest  = exp_d[i];
      step();
      chk("expl_onehot", 32'(out_valid), 32'(4'b0001 << exp_d[i]));
    end
    chk("expl_last_data0", 32'(out_data0), 32'hD4);
    in_valid = 1'b0;
    step();

    // Round-robin wrap from a fresh pointer.
    do_reset();
    mode      = 1'b1;
    out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      step();
      chk("rr_onehot", 32'(out_valid), 32'(4'b0001 << (i % 4)));
    end
    chk("rr_final_ptr", 32'(rr_ptr), 32'd2);
    in_valid = 1'b0;
    step();

    // Backpressure on channel 2.
    mode      = 1'b0;
    in_dest   = 2'd2;
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    step();
    in_data = 8'h6B;
    #1;
    chk("bp_blocked", 32'(in_ready), 32'd0);
    step();
    chk("bp_held", 32'(out_data2), 32'h5A);
    out_ready = 4'hF;
    #1;
    chk("bp_open", 32'(in_ready), 32'd1);
    step();
    chk("bp_replaced", 32'(out_data2), 32'h6B);
    chk("bp_valid2", 32'(out_valid[2]), 32'd1);
    in_valid = 1'b0;
    step();

    // Mode switch mid-stream.
    do_reset();
    mode     = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_data = 8'h22;
    step();
    chk("ms_ptr2", 32'(rr_ptr), 32'd2);
    mode    = 1'b0;
    in_dest = 2'd0;
    in_data = 8'h77;
    step();
    chk("ms_77", 32'(out_data0), 32'h77);
    mode    = 1'b1;
    in_data = 8'h88;
    step();
    chk("ms_88", 32'(out_data2), 32'h88);
    chk("ms_ptr3", 32'(rr_ptr), 32'd3);
    in_valid = 1'b0;
    step();

    // Reset with all slots full and stalled.
    mode      = 1'b0;
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_dest  = 2'(i);
      in_data  = 8'(8'hF0 + i);
      step();
    end
    chk("full_valid", 32'(out_valid), 32'hF);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", {out_data3, out_data2, out_data1, out_data0}, 32'd0);
    chk("mid_rst_ptr", 32'(rr_ptr), 32'd0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      mode      = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 2'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
